// File: rtl/pic_pkg.sv
// Shared PIC16F core definitions: program counter width, hardware stack depth,
// and the stack operation decoded from the control unit's push/pop strobes.
package pic_pkg;

    localparam int PC_WIDTH    = 13;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        PUSH    = 2'b01,
        POP     = 2'b10,
        REPLACE = 2'b11
    } stack_op_e;

    // Push and pop together means "replace the top entry", not two operations.
    function automatic stack_op_e decode_stack_op(input logic push_en, input logic pop_en);
        stack_op_e op;
        unique case ({push_en, pop_en})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = REPLACE;
            default: op = NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_regfile.sv
// DEPTH x WIDTH register array for the return-address stack.
// One synchronous write port, one asynchronous read port, synchronous reset to zero.
module pc_stack_regfile #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage register, cleared to zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pc_stack.sv
// PIC16F hardware return-address stack: circular DEPTH-level stack with wrap
// on overflow/underflow, occupancy count and sticky overflow/underflow flags.
// Optional macro PC_STACK_FAULT_EN adds a registered one-cycle stack_fault
// pulse after every new overflow/underflow event (STVREN-style reset request).
module pc_stack
    import pic_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PTR_W = $clog2(STACK_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_en,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_en,
    output logic [WIDTH-1:0] pop_data,
    output logic [PTR_W:0]   depth,
    input  logic             flag_clr,
    output logic             ovf_flag,
    output logic             unf_flag,
    output logic             stack_fault
);

    localparam logic [PTR_W:0] FULL_DEPTH = (PTR_W+1)'(DEPTH);

    stack_op_e        op;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] top_addr;
    logic [PTR_W:0]   depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_event;
    logic             unf_event;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    assign op       = decode_stack_op(push_en, pop_en);
    assign top_addr = ptr_q - PTR_W'(1);

    pc_stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (push_data),
        .rd_addr (top_addr),
        .rd_data (pop_data)
    );

    // Pointer, occupancy and write-port control; pointer wraps naturally at PTR_W bits.
    always_comb begin
        ptr_d   = ptr_q;
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        unique case (op)
            PUSH: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                ptr_d   = ptr_q + PTR_W'(1);
                if (depth_q != FULL_DEPTH) begin
                    depth_d = depth_q + (PTR_W+1)'(1);
                end
            end
            POP: begin
                ptr_d = top_addr;
                if (depth_q != '0) begin
                    depth_d = depth_q - (PTR_W+1)'(1);
                end
            end
            REPLACE: begin
                wr_en   = 1'b1;
                wr_addr = top_addr;
            end
            default: begin
            end
        endcase
    end

    // Sticky flags: a new event in the same cycle as flag_clr wins over the clear.
    always_comb begin
        ovf_event = (op == PUSH) && (depth_q == FULL_DEPTH);
        unf_event = (op == POP) && (depth_q == '0);
        ovf_d     = flag_clr ? 1'b0 : ovf_q;
        unf_d     = flag_clr ? 1'b0 : unf_q;
        if (ovf_event) begin
            ovf_d = 1'b1;
        end
        if (unf_event) begin
            unf_d = 1'b1;
        end
    end

    // Pointer, depth and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef PC_STACK_FAULT_EN
    logic fault_q, fault_d;

    // A fault pulses for every new event, even when the sticky flag is already set.
    always_comb begin
        fault_d = ovf_event | unf_event;
    end

    // Fault pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign stack_fault = fault_q;
`else
    assign stack_fault = 1'b0;
`endif

    assign depth    = depth_q;
    assign ovf_flag = ovf_q;
    assign unf_flag = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack: directed scenarios plus a randomized run checked
// against an array-based model of the stack. Honours PC_STACK_FAULT_EN.
module tb_pc_stack;
    import pic_pkg::*;

    localparam int W  = PC_WIDTH;
    localparam int D  = STACK_DEPTH;
    localparam int PW = $clog2(STACK_DEPTH);
`ifdef PC_STACK_FAULT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          push_en;
    logic [W-1:0]  push_data;
    logic          pop_en;
    logic [W-1:0]  pop_data;
    logic [PW:0]   depth;
    logic          flag_clr;
    logic          ovf_flag;
    logic          unf_flag;
    logic          stack_fault;

    int checks = 0;
    int errors = 0;

    int m_mem [D];
    int m_ptr;
    int m_depth;
    bit m_ovf;
    bit m_unf;
    bit m_fault;

    pc_stack dut (
        .clk         (clk),
        .rst         (rst),
        .push_en     (push_en),
        .push_data   (push_data),
        .pop_en      (pop_en),
        .pop_data    (pop_data),
        .depth       (depth),
        .flag_clr    (flag_clr),
        .ovf_flag    (ovf_flag),
        .unf_flag    (unf_flag),
        .stack_fault (stack_fault)
    );

    always #5 clk = ~clk;

    function automatic int model_top();
        return m_mem[(m_ptr + D - 1) % D];
    endfunction

    // Drive one clock cycle of stimulus and advance the model by the stack rules.
    task automatic drive_cycle(input bit p, input int data, input bit q, input bit c, input bit r);
        bit ev_o;
        bit ev_u;
        rst       = r;
        push_en   = p;
        push_data = W'(data);
        pop_en    = q;
        flag_clr  = c;
        @(posedge clk);
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_ptr = 0; m_depth = 0; m_ovf = 0; m_unf = 0; m_fault = 0;
        end else begin
            ev_o = p && !q && (m_depth == D);
            ev_u = q && !p && (m_depth == 0);
            if (p && q) begin
                m_mem[(m_ptr + D - 1) % D] = data % (1 << W);
            end else if (p) begin
                m_mem[m_ptr] = data % (1 << W);
                m_ptr = (m_ptr + 1) % D;
                if (m_depth < D) m_depth++;
            end else if (q) begin
                m_ptr = (m_ptr + D - 1) % D;
                if (m_depth > 0) m_depth--;
            end
            if (c) begin m_ovf = 0; m_unf = 0; end
            if (ev_o) m_ovf = 1;
            if (ev_u) m_unf = 1;
            m_fault = ev_o || ev_u;
        end
        #1;
        rst = 0; push_en = 0; pop_en = 0; flag_clr = 0; push_data = '0;
    endtask

    task automatic test_reset();
        drive_cycle(0, 0, 0, 0, 1);
        checks++; if (depth !== '0) begin errors++; $display("[TB] FAIL reset_depth got %0d want 0", depth); end
        checks++; if (pop_data !== '0) begin errors++; $display("[TB] FAIL reset_pop_data got %h want 0", pop_data); end
        checks++; if (ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got ovf=%b unf=%b want 0 0", ovf_flag, unf_flag); end
        checks++; if (stack_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b want 0", stack_fault); end
    endtask

    task automatic test_push_pop();
        int vals [3] = '{'h0030, 'h0020, 'h0010};
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(1, 'h0010, 0, 0, 0);
        drive_cycle(1, 'h0020, 0, 0, 0);
        drive_cycle(1, 'h0030, 0, 0, 0);
        checks++; if (depth !== 4'd3) begin errors++; $display("[TB] FAIL pp_depth3 got %0d want 3", depth); end
        checks++; if (pop_data !== 13'h0030) begin errors++; $display("[TB] FAIL pp_top got %h want 0030", pop_data); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pop_data !== W'(vals[i])) begin errors++; $display("[TB] FAIL pp_pop%0d got %h want %h", i, pop_data, vals[i]); end
            drive_cycle(0, 0, 1, 0, 0);
        end
        checks++; if (depth !== '0) begin errors++; $display("[TB] FAIL pp_depth0 got %0d want 0", depth); end
        checks++; if (ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin errors++; $display("[TB] FAIL pp_flags got ovf=%b unf=%b want 0 0", ovf_flag, unf_flag); end
    endtask

    task automatic test_overflow_underflow();
        drive_cycle(0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) drive_cycle(1, 'h0100 + i, 0, 0, 0);
        checks++; if (depth !== 4'd8) begin errors++; $display("[TB] FAIL ovf_depth got %0d want 8", depth); end
        checks++; if (ovf_flag !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", ovf_flag); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (pop_data !== W'('h0109 - i)) begin errors++; $display("[TB] FAIL ovf_pop%0d got %h want %h", i, pop_data, 'h0109 - i); end
            drive_cycle(0, 0, 1, 0, 0);
        end
        checks++; if (depth !== '0 || unf_flag !== 1'b0) begin errors++; $display("[TB] FAIL drained got depth=%0d unf=%b want 0 0", depth, unf_flag); end
        checks++; if (pop_data !== 13'h0109) begin errors++; $display("[TB] FAIL unf_wrap_data got %h want 0109", pop_data); end
        drive_cycle(0, 0, 1, 0, 0);
        checks++; if (unf_flag !== 1'b1 || depth !== '0) begin errors++; $display("[TB] FAIL unf_flag got unf=%b depth=%0d want 1 0", unf_flag, depth); end
    endtask

    task automatic test_replace();
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(1, 'h0555, 0, 0, 0);
        drive_cycle(1, 'h0AAA, 0, 0, 0);
        checks++; if (pop_data !== 13'h0AAA) begin errors++; $display("[TB] FAIL rep_before got %h want 0aaa", pop_data); end
        drive_cycle(1, 'h1FFF, 1, 0, 0);
        checks++; if (depth !== 4'd2 || pop_data !== 13'h1FFF) begin errors++; $display("[TB] FAIL rep_top got depth=%0d data=%h want 2 1fff", depth, pop_data); end
        checks++; if (ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin errors++; $display("[TB] FAIL rep_flags got ovf=%b unf=%b want 0 0", ovf_flag, unf_flag); end
        drive_cycle(0, 0, 1, 0, 0);
        checks++; if (pop_data !== 13'h0555) begin errors++; $display("[TB] FAIL rep_below got %h want 0555", pop_data); end
    endtask

    task automatic test_flag_clr();
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) drive_cycle(1, 'h0200 + i, 0, 0, 0);
        checks++; if (ovf_flag !== 1'b1 || unf_flag !== 1'b1) begin errors++; $display("[TB] FAIL clr_set got ovf=%b unf=%b want 1 1", ovf_flag, unf_flag); end
        drive_cycle(0, 0, 0, 1, 0);
        checks++; if (ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin errors++; $display("[TB] FAIL clr_clear got ovf=%b unf=%b want 0 0", ovf_flag, unf_flag); end
        drive_cycle(1, 'h0333, 0, 1, 0);
        checks++; if (ovf_flag !== 1'b1 || unf_flag !== 1'b0) begin errors++; $display("[TB] FAIL clr_set_wins got ovf=%b unf=%b want 1 0", ovf_flag, unf_flag); end
    endtask

    task automatic test_reset_override();
        drive_cycle(1, 'h0123, 0, 0, 1);
        checks++; if (depth !== '0 || pop_data !== '0) begin errors++; $display("[TB] FAIL rst_push got depth=%0d data=%h want 0 0", depth, pop_data); end
        for (int i = 0; i < 5; i++) drive_cycle(1, 'h0400 + i, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 0, 0);
        checks++; if (unf_flag !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_unf got %b want 1", unf_flag); end
        drive_cycle(0, 0, 0, 0, 1);
        checks++; if (depth !== '0 || pop_data !== '0 || ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid got depth=%0d data=%h ovf=%b unf=%b want 0 0 0 0", depth, pop_data, ovf_flag, unf_flag);
        end
    endtask

    task automatic test_fault();
        drive_cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1, 'h0500 + i, 0, 0, 0);
            checks++; if (stack_fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_quiet%0d got %b want 0", i, stack_fault); end
        end
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1, 'h0600 + k, 0, 0, 0);
            checks++; if (stack_fault !== FAULT_ON) begin errors++; $display("[TB] FAIL fault_pulse%0d got %b want %b", k, stack_fault, FAULT_ON); end
            drive_cycle(0, 0, 0, 0, 0);
            checks++; if (stack_fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_end%0d got %b want 0", k, stack_fault); end
        end
    endtask

    task automatic test_random();
        bit p, q, c, r;
        int data;
        for (int n = 0; n < 400; n++) begin
            r    = ($urandom_range(0, 49) == 0);
            p    = $urandom_range(0, 1);
            q    = $urandom_range(0, 1);
            c    = ($urandom_range(0, 7) == 0);
            data = $urandom_range(0, (1 << W) - 1);
            checks++; if (pop_data !== W'(model_top())) begin errors++; $display("[TB] FAIL rnd_top@%0d got %h want %h", n, pop_data, model_top()); end
            drive_cycle(p, data, q, c, r);
            checks++;
            if (depth !== (PW+1)'(m_depth) || ovf_flag !== m_ovf || unf_flag !== m_unf || stack_fault !== (m_fault & FAULT_ON)) begin
                errors++;
                $display("[TB] FAIL rnd_state@%0d got depth=%0d ovf=%b unf=%b fault=%b want %0d %b %b %b",
                         n, depth, ovf_flag, unf_flag, stack_fault, m_depth, m_ovf, m_unf, m_fault & FAULT_ON);
            end
        end
    endtask

    initial begin
        rst = 1'b1; push_en = 1'b0; pop_en = 1'b0; flag_clr = 1'b0; push_data = '0;
        test_reset();
        test_push_pop();
        test_overflow_underflow();
        test_replace();
        test_flag_clr();
        test_reset_override();
        test_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
